// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_arbiter
//  Purpose  : Shares one backing-memory beat port between NREQ cache
//             requesters. It picks one winner and keeps the port for a
//             whole BEATS-beat line. A line is either a refill (read) or a
//             writeback (write).
//  Options  : CACHE_ARB_FIXED_PRIO_EN - when defined, the lowest-index
//             valid requester always wins. When undefined (default), the
//             winner is chosen round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int NREQ  = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int BEATS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      wdata_ready,
    output logic [DW-1:0]        rdata,
    output logic [NREQ-1:0]      rdata_valid,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic                 mem_rvalid,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int OW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW         = $clog2(BEATS);
    localparam int BOFF       = $clog2(DW / 8);
    localparam int LINE_BYTES = BEATS * (DW / 8);
    localparam logic [AW-1:0] LINE_MASK = ~AW'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_RWAIT = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BW-1:0]   r_beat;
    logic [BW-1:0]   w_beat_nxt;
    logic [OW-1:0]   r_owner;
    logic            r_we;
    logic [AW-1:0]   r_base;
    logic [OW-1:0]   r_last;
    logic            w_load;
    logic            w_any;
    logic [OW-1:0]   w_winner;
    logic            w_last_beat;
    logic [AW-1:0]   w_beat_addr;

    // The beat index is OR-ed into the zeroed offset bits of the line base,
    // so the address wraps inside the line and never carries into the tag.
    assign w_beat_addr = r_base | (AW'(r_beat) << BOFF);
    assign w_last_beat = (r_beat == BW'(BEATS - 1));

`ifdef CACHE_ARB_FIXED_PRIO_EN
    // Winner select: lowest-index valid requester.
    always_comb begin
        w_any    = |req_valid;
        w_winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_winner = OW'(i);
            end
        end
    end
`else
    logic            w_found;
    logic [OW-1:0]   w_idx;

    // Winner select: first valid requester scanning upward from last_grant+1.
    always_comb begin
        w_any    = |req_valid;
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = OW'((int'(r_last) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end
`endif

    // Burst sequencer: next state and all outputs. During reset, every
    // output is forced to zero.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_load      = 1'b0;
        req_ready   = '0;
        wdata_ready = '0;
        rdata       = '0;
        rdata_valid = '0;
        done        = '0;
        busy        = 1'b0;
        mem_valid   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (!rst) begin
            busy = (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        req_ready[w_winner] = 1'b1;
                        w_load              = 1'b1;
                        w_state_nxt         = S_CMD;
                    end
                end
                S_CMD: begin
                    mem_valid = 1'b1;
                    mem_we    = r_we;
                    mem_addr  = w_beat_addr;
                    if (r_we) begin
                        mem_wdata            = wdata[r_owner*DW +: DW];
                        wdata_ready[r_owner] = mem_ready;
                    end
                    if (mem_ready) begin
                        if (r_we) begin
                            if (w_last_beat) begin
                                w_state_nxt = S_FIN;
                            end else begin
                                w_beat_nxt = r_beat + 1'b1;
                            end
                        end else begin
                            w_state_nxt = S_RWAIT;
                        end
                    end
                end
                S_RWAIT: begin
                    if (mem_rvalid) begin
                        rdata                = mem_rdata;
                        rdata_valid[r_owner] = 1'b1;
                        if (w_last_beat) begin
                            w_state_nxt = S_FIN;
                        end else begin
                            w_beat_nxt  = r_beat + 1'b1;
                            w_state_nxt = S_CMD;
                        end
                    end
                end
                S_FIN: begin
                    done[r_owner] = 1'b1;
                    w_beat_nxt    = '0;
                    w_state_nxt   = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, beat counter and the burst context latched at accept time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_owner <= '0;
            r_we    <= 1'b0;
            r_base  <= '0;
            r_last  <= OW'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_load) begin
                r_owner <= w_winner;
                r_we    <= req_we[w_winner];
                r_base  <= req_addr[w_winner*AW +: AW] & LINE_MASK;
                r_last  <= w_winner;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_mem_arbiter
//  Purpose  : Self-checking bench for cache_mem_arbiter. Expected grants,
//             beat addresses, data and done pulses are queued when a burst
//             is issued, then popped as the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    localparam int NREQ  = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BEATS = 4;
`ifdef CACHE_ARB_FIXED_PRIO_EN
    localparam int W_SECOND = 0;
`else
    localparam int W_SECOND = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   wdata_ready;
    logic [DW-1:0]     rdata;
    logic [NREQ-1:0]   rdata_valid;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .BEATS(BEATS)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_ready(req_ready), .wdata(wdata), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .busy(busy),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        bit          hold;       // keep req_valid asserted after the grant
        int          win;        // expected winner
        int          stall_beat; // beat whose command sees 3 not-ready cycles
        bit          chk_lat;
        bit          chk_turn;
    } vec_t;

    vec_t tbl [6];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int          q_grant [$];
    logic [31:0] q_addr  [$];
    logic [31:0] q_wd    [$];
    logic [31:0] q_rd    [$];
    logic [1:0]  q_done  [$];

    bit          mon_en = 1'b0;
    logic [1:0]  cur_oh = 2'b00;
    logic        cur_we = 1'b0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    int          wr_cnt = 0;
    int          g;

    int          cmd_cnt = 0;
    int          stall_beat = -1;
    int          stall_left = 0;
    int          wbeat [2];

    task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory and requester-data model: zero-wait reads return 0xA0 + word
    // index within the line; each requester supplies 0xD0 + 0x100*id + beat.
    initial begin
        logic        acc;
        logic        racc;
        logic [31:0] addr_s;
        logic [1:0]  wr_s;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        wbeat[0]   = 0;
        wbeat[1]   = 0;
        wdata      = {32'h1D0, 32'hD0};
        forever begin
            @(negedge clk);
            acc    = mem_valid && mem_ready;
            racc   = acc && !mem_we;
            addr_s = mem_addr;
            wr_s   = wdata_ready;
            @(posedge clk);
            #1;
            if (acc) cmd_cnt++;
            mem_rvalid = racc;
            mem_rdata  = racc ? (32'hA0 + 32'(addr_s[3:2])) : 32'h0;
            for (int r = 0; r < 2; r++) begin
                if (wr_s[r]) wbeat[r]++;
            end
            wdata = {32'h1D0 + 32'(wbeat[1]), 32'hD0 + 32'(wbeat[0])};
            if (cmd_cnt == stall_beat && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (req_ready != 0) begin
                    acc_cyc = cyc;
                    if (q_grant.size() == 0) chk_eq("grant_unexpected", 64'(req_ready), 64'h0);
                    else begin
                        g = q_grant.pop_front();
                        chk_eq("grant", 64'(req_ready), 64'(g == 1 ? 2'b10 : 2'b01));
                    end
                end
                if (mem_valid) begin
                    if (q_addr.size() == 0) chk_eq("cmd_unexpected", 64'(mem_addr), 64'h0);
                    else begin
                        chk_eq("mem_addr", 64'(mem_addr), 64'(q_addr[0]));
                        chk_eq("mem_we", 64'(mem_we), 64'(cur_we));
                        if (cur_we && q_wd.size() != 0) chk_eq("mem_wdata", 64'(mem_wdata), 64'(q_wd[0]));
                        if (mem_ready) begin
                            void'(q_addr.pop_front());
                            if (cur_we && q_wd.size() != 0) void'(q_wd.pop_front());
                        end
                    end
                end
                if (wdata_ready != 0) begin
                    wr_cnt++;
                    chk_eq("wdata_ready", 64'(wdata_ready), 64'(cur_oh));
                end
                if (rdata_valid != 0) begin
                    chk_eq("rdata_valid", 64'(rdata_valid), 64'(cur_oh));
                    if (q_rd.size() == 0) chk_eq("rdata_unexpected", 64'(rdata), 64'h0);
                    else chk_eq("rdata", 64'(rdata), 64'(q_rd.pop_front()));
                end
                if (done != 0) begin
                    done_cyc = cyc;
                    if (q_done.size() == 0) chk_eq("done_unexpected", 64'(done), 64'h0);
                    else chk_eq("done", 64'(done), 64'(q_done.pop_front()));
                end
            end
        end
    end

    // Issue one line burst, queue its expectations, wait for completion.
    task automatic run_entry(input vec_t v);
        logic [31:0] a;
        logic [31:0] base;
        int          prev_done;
        bit          got;
        a          = (v.win == 1) ? v.a1 : v.a0;
        base       = a & 32'hFFFF_FFF0;
        prev_done  = done_cyc;
        cmd_cnt    = 0;
        wbeat[0]   = 0;
        wbeat[1]   = 0;
        wr_cnt     = 0;
        stall_beat = v.stall_beat;
        stall_left = (v.stall_beat >= 0) ? 3 : 0;
        cur_oh     = (v.win == 1) ? 2'b10 : 2'b01;
        cur_we     = v.we[v.win];
        q_grant.push_back(v.win);
        for (int b = 0; b < BEATS; b++) begin
            q_addr.push_back(base + 32'(4 * b));
            if (cur_we) q_wd.push_back(((v.win == 1) ? 32'h1D0 : 32'hD0) + 32'(b));
            else        q_rd.push_back(32'hA0 + 32'(b));
        end
        q_done.push_back(cur_oh);
        req_valid = v.valid;
        req_we    = v.we;
        req_addr  = {v.a1, v.a0};

        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (req_ready != 0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk_eq("grant_timeout", 64'h0, 64'h1);
        @(posedge clk);
        #1;
        if (!v.hold) req_valid = 2'b00;

        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (done != 0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk_eq("done_timeout", 64'h0, 64'h1);
        // Zero-wait refill: done lands in the 10th cycle counting the accept cycle.
        if (v.chk_lat)  chk_eq("refill_latency", 64'(done_cyc - acc_cyc), 64'd9);
        if (v.chk_turn) chk_eq("turnaround", 64'(acc_cyc - prev_done), 64'd1);
        chk_eq("wdata_ready_count", 64'(wr_cnt), cur_we ? 64'd4 : 64'd0);
        chk_eq("queues_drained",
               64'(q_grant.size() + q_addr.size() + q_wd.size() + q_rd.size() + q_done.size()),
               64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        bit   got;
        int   dcnt;
        //        valid  we     a0             a1            hold win       stall lat turn
        tbl[0] = '{2'b11, 2'b00, 32'h0000_3000, 32'h0000_4008, 1'b1, 0,        -1, 1'b0, 1'b0};
        tbl[1] = '{2'b11, 2'b00, 32'h0000_3000, 32'h0000_4008, 1'b1, W_SECOND, -1, 1'b0, 1'b1};
        tbl[2] = '{2'b11, 2'b00, 32'h0000_3000, 32'h0000_4008, 1'b0, 0,        -1, 1'b0, 1'b1};
        tbl[3] = '{2'b01, 2'b00, 32'h0000_1004, 32'h0000_0000, 1'b0, 0,        -1, 1'b1, 1'b0};
        tbl[4] = '{2'b10, 2'b10, 32'h0000_0000, 32'h0000_2000, 1'b0, 1,         2, 1'b0, 1'b0};
        tbl[5] = '{2'b01, 2'b00, 32'hFFFF_FFF8, 32'h0000_0000, 1'b0, 0,        -1, 1'b0, 1'b0};

        rst       = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("reset_req_ready", 64'(req_ready), 64'h0);
        chk_eq("reset_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst       = 1'b0;
        @(negedge clk);
        chk_eq("idle_busy", 64'(busy), 64'h0);
        chk_eq("idle_outputs", 64'(|{req_ready, wdata_ready, rdata_valid, done, mem_valid,
                                      mem_we, mem_addr, mem_wdata, rdata}), 64'h0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int e = 0; e < 6; e++) begin
            run_entry(tbl[e]);
        end

        // Reset while requester 0 waits for the beat-1 read data.
        mon_en    = 1'b0;
        cmd_cnt   = 0;
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {32'h0, 32'h0000_5000};
        got       = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            req_valid = 2'b00;
            if (cmd_cnt == 2) begin
                got = 1'b1;
                break;
            end
        end
        chk_eq("reach_rwait_beat1", 64'(got), 64'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_eq("midreset_busy", 64'(busy), 64'h0);
        chk_eq("midreset_outputs", 64'(|{req_ready, wdata_ready, rdata_valid, done, mem_valid,
                                          mem_we, mem_addr, mem_wdata, rdata}), 64'h0);
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done != 0 || busy) dcnt++;
        end
        chk_eq("midreset_no_done", 64'(dcnt), 64'h0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        done_cyc = 0;
        rv = '{2'b11, 2'b00, 32'h0000_6000, 32'h0000_7000, 1'b0, 0, -1, 1'b0, 1'b0};
        run_entry(rv);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
